// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  localparam logic [4:0] CNT_LAST = 5'd31;

endpackage

// File: rtl/alu.sv
// 32-bit combinational ALU: add, sub, and, or, signed set-less-than.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result follows the inputs.
module alu
  import muldiv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alucontrol,
  output logic [31:0] result,
  output logic        zero,
  output logic        carry
);

  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        ovf;

  // Shared adder: subtraction is a + ~b + 1, so one carry chain serves both.
  always_comb begin
    b_eff  = alucontrol[0] ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, alucontrol[0]};
    ovf    = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    result = 32'd0;
    case (alucontrol)
      ALU_ADD, ALU_SUB: result = sum[31:0];
      ALU_AND:          result = a & b;
      ALU_OR:           result = a | b;
      ALU_SLT:          result = {31'd0, sum[31] ^ ovf};
      default:          result = 32'd0;
    endcase
    zero  = (result == 32'd0);
    carry = sum[32];
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative MUL/MULHU/DIVU/REMU sequencer reusing one private 32-bit ALU per step.
// Latency: 33 cycles accept-to-response; divide-by-zero responds after 1 cycle.
// Backpressure: req_ready only in IDLE; response held in DONE until resp_ready.
module alu_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_dbz,
  output logic            busy
);

  // hi: acc_hi while multiplying, partial remainder R while dividing.
  // lo: multiplier shifting out while multiplying; dividend shifting out
  //     with quotient bits shifting in behind it while dividing.
  // opb: multiplicand or divisor, constant for the whole operation.
  state_e      state_q, state_d;
  op_e         op_q,    op_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic [31:0] opb_q,   opb_d;
  logic [31:0] res_q,   res_d;
  logic        dbz_q,   dbz_d;

  logic        is_div;
  logic [31:0] rem_shift;
  logic [31:0] alu_a;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_unused;
  logic        mul_c;
  logic        div_ge;
  logic [31:0] step_hi;
  logic [31:0] step_lo;

  assign is_div    = op_q[1];
  assign rem_shift = {hi_q[30:0], lo_q[31]};
  assign alu_a     = is_div ? rem_shift : hi_q;
  assign alu_ctl   = is_div ? ALU_SUB : ALU_ADD;

  alu u_alu (
    .a          (alu_a),
    .b          (opb_q),
    .alucontrol (alu_ctl),
    .result     (alu_res),
    .zero       (alu_zero),
    .carry      (alu_carry)
  );

  // Only the sum is needed; the carry is rebuilt from operand/sum sign bits.
  assign alu_unused = alu_zero | alu_carry;

  // One shift-add or restoring-divide step from the current registers.
  always_comb begin
    mul_c   = (hi_q[31] & opb_q[31]) | ((hi_q[31] | opb_q[31]) & ~alu_res[31]);
    div_ge  = hi_q[31] |
              ((rem_shift[31] == opb_q[31]) ? ~alu_res[31] : rem_shift[31]);
    step_hi = hi_q;
    step_lo = lo_q;
    if (is_div) begin
      step_hi = div_ge ? alu_res : rem_shift;
      step_lo = {lo_q[30:0], div_ge};
    end else if (lo_q[0]) begin
      step_hi = {mul_c, alu_res[31:1]};
      step_lo = {alu_res[0], lo_q[31:1]};
    end else begin
      step_hi = {1'b0, hi_q[31:1]};
      step_lo = {hi_q[0], lo_q[31:1]};
    end
  end

  // Sequencer FSM and datapath next-state; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          op_d  = op_e'(req_op);
          cnt_d = 5'd0;
          hi_d  = 32'd0;
          if (req_op[1] && (req_b == 32'd0)) begin
            state_d = ST_DONE;
            res_d   = (op_e'(req_op) == OP_DIVU) ? 32'hFFFF_FFFF : req_a;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
            dbz_d   = 1'b0;
            lo_d    = req_op[1] ? req_a : req_b;
            opb_d   = req_op[1] ? req_b : req_a;
          end
        end
      end
      ST_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          // MULHU and REMU read the high half; MUL and DIVU the low half.
          res_d   = op_q[0] ? step_hi : step_lo;
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      opb_q   <= 32'd0;
      res_q   <= 32'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign resp_result = res_q;
  assign resp_dbz    = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with hand-computed results and latencies.
// Latency: checks 33-cycle ops, 1-cycle divide-by-zero, 1-cycle re-ready.
// Backpressure: exercises held responses, flush and mid-run reset.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_dbz;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_dbz    (resp_dbz),
    .busy        (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency to resp_valid, check result, handshake.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input logic exp_dbz,
                        input int exp_lat);
    int n;
    int busy_bad;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    tick;
    req_valid = 1'b0;
    n         = 1;
    busy_bad  = 0;
    while (!resp_valid && n < 40) begin
      if (!busy) busy_bad++;
      tick;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_busy"}, busy_bad + (busy ? 0 : 1), 32'd0);
    chk({tag, "_res"}, resp_result, exp);
    chk({tag, "_dbz"}, {31'd0, resp_dbz}, {31'd0, exp_dbz});
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk({tag, "_rerdy"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_novld"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int bad;
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;

    chk("rst_rdy",  {31'd0, req_ready},  32'd1);
    chk("rst_vld",  {31'd0, resp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy},       32'd0);
    chk("rst_res",  resp_result,         32'd0);
    chk("rst_dbz",  {31'd0, resp_dbz},   32'd0);

    run_op("mul7x6",   2'b00, 32'd7,         32'd6,         32'd42,        1'b0, 33);
    run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    run_op("mul_ff",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
    run_op("mul_sh",   2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0, 33);
    run_op("mulhu_sh", 2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 1'b0, 33);
    run_op("divu100",  2'b10, 32'd100,       32'd7,         32'd14,        1'b0, 33);
    run_op("remu100",  2'b11, 32'd100,       32'd7,         32'd2,         1'b0, 33);
    run_op("divu_ff1", 2'b10, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0, 33);
    run_op("divu_f16", 2'b10, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 1'b0, 33);
    run_op("remu_top", 2'b11, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 1'b0, 33);
    run_op("divu_dbz", 2'b10, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1'b1, 1);
    run_op("remu_dbz", 2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b1, 1);

    // Flush in cycle k+10 of a multiply.
    req_op = 2'b00; req_a = 32'd7; req_b = 32'd6; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (9) tick;
    chk("fl_busy_pre", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fl_rdy",  {31'd0, req_ready}, 32'd1);
    chk("fl_busy", {31'd0, busy},      32'd0);
    bad = 0;
    repeat (40) begin
      if (resp_valid) bad++;
      tick;
    end
    chk("fl_novld", bad, 32'd0);

    // Flush together with a request in IDLE: nothing accepted.
    req_op = 2'b10; req_a = 32'd5; req_b = 32'd0; req_valid = 1'b1; flush = 1'b1;
    tick;
    req_valid = 1'b0; flush = 1'b0;
    chk("flv_busy", {31'd0, busy},      32'd0);
    chk("flv_rdy",  {31'd0, req_ready}, 32'd1);
    bad = 0;
    repeat (36) begin
      if (resp_valid) bad++;
      tick;
    end
    chk("flv_novld", bad, 32'd0);

    // Response held for 5 cycles with resp_ready low.
    req_op = 2'b00; req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (32) tick;
    chk("hold_vld", {31'd0, resp_valid}, 32'd1);
    bad = 0;
    repeat (5) begin
      if (resp_result !== 32'd15 || req_ready !== 1'b0 || resp_valid !== 1'b1) bad++;
      tick;
    end
    chk("hold_stable", bad, 32'd0);
    chk("hold_res", resp_result, 32'd15);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    chk("hold_rerdy", {31'd0, req_ready}, 32'd1);

    // Reset pulsed during RUN.
    req_op = 2'b01; req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_rdy",  {31'd0, req_ready},  32'd1);
    chk("mrst_vld",  {31'd0, resp_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy},       32'd0);
    chk("mrst_res",  resp_result,         32'd0);
    chk("mrst_dbz",  {31'd0, resp_dbz},   32'd0);

    run_op("post_rst", 2'b00, 32'd7, 32'd6, 32'd42, 1'b0, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
